max31855_monitor: RTL and testbench

Sits directly downstream of the MAX31855 SPI reader: schedules its periodic READ requests, captures each completed conversion, screens fault bits, and keeps a moving average of the 14-bit thermocouple temperature. Provides a validated average, an over-temperature alarm with hysteresis, a latched fault report and a transaction timeout flag to the system controller.

---
 rtl/max31855_monitor.sv | 241 ++++++++++++++++++++++++
 tb/tb_max31855_monitor.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/max31855_monitor.sv
// ---------------------------------------------------------------------------
// max31855_monitor
//
// Sits downstream of the MAX31855 SPI reader. Schedules periodic READ
// requests, captures each completed conversion, screens the reader fault
// bits, keeps a moving average of the 14-bit thermocouple temperature and
// raises an over-temperature alarm with hysteresis.
//
// Ports:
//   SYSCLK          in   system clock, rising edge
//   RESET           in   asynchronous active-high reset
//   ENABLE          in   run enable; low stops new requests
//   READ            out  one-cycle request pulse to the reader
//   BUSY_FLAG       in   reader busy; falling edge marks data valid
//   STATUS_FAULT    in   [2:0] reader fault bits
//   TEMPERATURE_TC  in   [13:0] signed temperature, 0.25 degC/LSB
//   TEMP_AVG        out  [13:0] signed moving average, 0.25 degC/LSB
//   AVG_VALID       out  averaging window full since reset/flush
//   SAMPLE_STROBE   out  one-cycle pulse when TEMP_AVG updates
//   OVER_TEMP       out  over-temperature alarm
//   FAULT_LATCHED   out  sticky fault indicator
//   FAULT_CODE      out  [2:0] fault bits of the sample that latched
//   FAULT_CLEAR     in   clears FAULT_LATCHED, FAULT_CODE, TIMEOUT_ERR
//   TIMEOUT_ERR     out  sticky reader transaction timeout
// ---------------------------------------------------------------------------
module max31855_monitor #(
    parameter int SAMPLE_PERIOD = 2500000,
    parameter int AVG_LOG2      = 3,
    parameter int HI_LIMIT      = 400,
    parameter int HYST          = 8,
    parameter int FAULT_LIMIT   = 3,
    parameter int BUSY_TIMEOUT  = 4096
) (
    input  logic        SYSCLK,
    input  logic        RESET,
    input  logic        ENABLE,
    output logic        READ,
    input  logic        BUSY_FLAG,
    input  logic [2:0]  STATUS_FAULT,
    input  logic [13:0] TEMPERATURE_TC,
    output logic [13:0] TEMP_AVG,
    output logic        AVG_VALID,
    output logic        SAMPLE_STROBE,
    output logic        OVER_TEMP,
    output logic        FAULT_LATCHED,
    output logic [2:0]  FAULT_CODE,
    input  logic        FAULT_CLEAR,
    output logic        TIMEOUT_ERR
);

    localparam int WINDOW = 1 << AVG_LOG2;
    localparam int SW     = 14 + AVG_LOG2;
    localparam int PW     = $clog2(SAMPLE_PERIOD + 1);
    localparam int TW     = $clog2(BUSY_TIMEOUT + 17);

    localparam logic [PW-1:0]       PERIOD_RELOAD = PW'(SAMPLE_PERIOD - 1);
    localparam logic [TW-1:0]       BUSY_LAST     = TW'(BUSY_TIMEOUT - 1);
    localparam logic [TW-1:0]       START_LAST    = TW'(15);
    localparam logic [AVG_LOG2:0]   FILL_FULL     = (AVG_LOG2 + 1)'(WINDOW);
    localparam logic [AVG_LOG2:0]   FILL_ONE      = (AVG_LOG2 + 1)'(1);
    localparam logic [AVG_LOG2-1:0] PTR_ONE       = AVG_LOG2'(1);
    localparam logic [3:0]          FAULT_LIM     = 4'(FAULT_LIMIT);
    localparam logic signed [13:0]  ALARM_SET     = 14'(HI_LIMIT);
    localparam logic signed [13:0]  ALARM_REL     = 14'(HI_LIMIT - HYST);

    typedef enum logic [2:0] {
        IDLE,
        REQUEST,
        WAIT_BUSY,
        WAIT_DONE,
        CAPTURE
    } state_t;

    state_t               state;
    logic [PW-1:0]        period_cnt;
    logic [TW-1:0]        wait_cnt;
    logic                 busy_q;
    logic                 busy_fall;
    logic signed [13:0]   cap_temp;
    logic [2:0]           cap_fault;

    logic signed [13:0]   sample_buf [WINDOW];
    logic [AVG_LOG2-1:0]  wr_ptr;
    logic [AVG_LOG2:0]    fill;
    logic [AVG_LOG2:0]    fill_next;
    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] new_sum;
    logic signed [13:0]   oldest;
    logic signed [13:0]   avg_next;
    logic signed [13:0]   avg_now;
    logic [3:0]           fault_cnt;
    logic [3:0]           fault_next;
    logic                 sample_good;

    assign busy_fall   = busy_q & ~BUSY_FLAG;
    assign sample_good = (cap_fault == 3'b000);
    assign avg_now     = TEMP_AVG;

    // Request/handshake sequencer. The period counter runs down on its own
    // so the READ spacing is measured from the previous READ, not from the
    // end of the previous transaction.
    always_ff @(posedge SYSCLK or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            READ        <= 1'b0;
            period_cnt  <= '0;
            wait_cnt    <= '0;
            busy_q      <= 1'b0;
            cap_temp    <= '0;
            cap_fault   <= '0;
            TIMEOUT_ERR <= 1'b0;
        end else begin
            busy_q <= BUSY_FLAG;
            READ   <= 1'b0;
            if (period_cnt != '0) begin
                period_cnt <= period_cnt - PW'(1);
            end
            // A timeout raised below in the same cycle overrides the clear.
            if (FAULT_CLEAR) begin
                TIMEOUT_ERR <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (ENABLE && !BUSY_FLAG && period_cnt == '0) begin
                        state      <= REQUEST;
                        READ       <= 1'b1;
                        period_cnt <= PERIOD_RELOAD;
                    end
                end
                REQUEST: begin
                    state    <= WAIT_BUSY;
                    wait_cnt <= '0;
                end
                WAIT_BUSY: begin
                    if (BUSY_FLAG) begin
                        state    <= WAIT_DONE;
                        wait_cnt <= '0;
                    end else if (wait_cnt == START_LAST) begin
                        TIMEOUT_ERR <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (busy_fall) begin
                        cap_temp  <= TEMPERATURE_TC;
                        cap_fault <= STATUS_FAULT;
                        state     <= CAPTURE;
                    end else if (BUSY_FLAG) begin
                        if (wait_cnt == BUSY_LAST) begin
                            TIMEOUT_ERR <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            wait_cnt <= wait_cnt + TW'(1);
                        end
                    end
                end
                CAPTURE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Until the window has filled, the slot being overwritten holds no real
    // sample, so it contributes zero to the running sum.
    always_comb begin
        oldest = '0;
        if (fill == FILL_FULL) begin
            oldest = sample_buf[wr_ptr];
        end
        new_sum    = sum + {{AVG_LOG2{cap_temp[13]}}, cap_temp}
                         - {{AVG_LOG2{oldest[13]}}, oldest};
        avg_next   = 14'(new_sum >>> AVG_LOG2);
        fill_next  = (fill == FILL_FULL) ? fill : fill + FILL_ONE;
        fault_next = (fault_cnt == 4'hF) ? fault_cnt : fault_cnt + 4'd1;
    end

    // Sample processing, fault screening and alarm. The alarm is evaluated
    // the cycle after SAMPLE_STROBE, using the freshly registered average.
    always_ff @(posedge SYSCLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < WINDOW; i++) begin
                sample_buf[i] <= '0;
            end
            wr_ptr        <= '0;
            fill          <= '0;
            sum           <= '0;
            fault_cnt     <= '0;
            TEMP_AVG      <= '0;
            AVG_VALID     <= 1'b0;
            SAMPLE_STROBE <= 1'b0;
            OVER_TEMP     <= 1'b0;
            FAULT_LATCHED <= 1'b0;
            FAULT_CODE    <= '0;
        end else begin
            SAMPLE_STROBE <= 1'b0;
            if (FAULT_CLEAR) begin
                FAULT_LATCHED <= 1'b0;
                FAULT_CODE    <= '0;
            end
            if (SAMPLE_STROBE) begin
                if (AVG_VALID && avg_now >= ALARM_SET) begin
                    OVER_TEMP <= 1'b1;
                end else if (!AVG_VALID || avg_now < ALARM_REL) begin
                    OVER_TEMP <= 1'b0;
                end
            end
            if (state == CAPTURE) begin
                if (sample_good) begin
                    fault_cnt          <= '0;
                    sample_buf[wr_ptr] <= cap_temp;
                    wr_ptr             <= wr_ptr + PTR_ONE;
                    fill               <= fill_next;
                    sum                <= new_sum;
                    TEMP_AVG           <= avg_next;
                    SAMPLE_STROBE      <= 1'b1;
                    AVG_VALID          <= (fill_next == FILL_FULL);
                end else begin
                    fault_cnt <= fault_next;
                    // Once latched, later faults only advance the counter.
                    if (!FAULT_LATCHED && fault_next >= FAULT_LIM) begin
                        FAULT_LATCHED <= 1'b1;
                        FAULT_CODE    <= cap_fault;
                        wr_ptr        <= '0;
                        fill          <= '0;
                        sum           <= '0;
                        TEMP_AVG      <= '0;
                        AVG_VALID     <= 1'b0;
                        OVER_TEMP     <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_max31855_monitor.sv
// ---------------------------------------------------------------------------
// tb_max31855_monitor
//
// Drives max31855_monitor with a behavioural MAX31855 reader and compares
// every processed sample against a window-of-recent-samples model.
// ---------------------------------------------------------------------------
module tb_max31855_monitor;

    localparam int PERIOD = 1000;
    localparam int LOG2   = 2;
    localparam int WIN    = 1 << LOG2;
    localparam int HI     = 400;
    localparam int HYS    = 8;
    localparam int FLIM   = 3;
    localparam int BTO    = 4096;

    logic        SYSCLK = 1'b0;
    logic        RESET;
    logic        ENABLE;
    logic        READ;
    logic        BUSY_FLAG;
    logic [2:0]  STATUS_FAULT;
    logic [13:0] TEMPERATURE_TC;
    logic [13:0] TEMP_AVG;
    logic        AVG_VALID;
    logic        SAMPLE_STROBE;
    logic        OVER_TEMP;
    logic        FAULT_LATCHED;
    logic [2:0]  FAULT_CODE;
    logic        FAULT_CLEAR;
    logic        TIMEOUT_ERR;

    max31855_monitor #(
        .SAMPLE_PERIOD(PERIOD),
        .AVG_LOG2     (LOG2),
        .HI_LIMIT     (HI),
        .HYST         (HYS),
        .FAULT_LIMIT  (FLIM),
        .BUSY_TIMEOUT (BTO)
    ) dut (
        .SYSCLK        (SYSCLK),
        .RESET         (RESET),
        .ENABLE        (ENABLE),
        .READ          (READ),
        .BUSY_FLAG     (BUSY_FLAG),
        .STATUS_FAULT  (STATUS_FAULT),
        .TEMPERATURE_TC(TEMPERATURE_TC),
        .TEMP_AVG      (TEMP_AVG),
        .AVG_VALID     (AVG_VALID),
        .SAMPLE_STROBE (SAMPLE_STROBE),
        .OVER_TEMP     (OVER_TEMP),
        .FAULT_LATCHED (FAULT_LATCHED),
        .FAULT_CODE    (FAULT_CODE),
        .FAULT_CLEAR   (FAULT_CLEAR),
        .TIMEOUT_ERR   (TIMEOUT_ERR)
    );

    always #5 SYSCLK = ~SYSCLK;

    int cyc = 0;
    int strobe_cnt = 0;
    always @(posedge SYSCLK) cyc <= cyc + 1;
    always @(negedge SYSCLK) if (SAMPLE_STROBE) strobe_cnt <= strobe_cnt + 1;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model state: the most recent good samples since the last flush.
    int window[$];
    int m_avg, m_valid, m_over, m_latched, m_code, m_timeout, m_fcnt;

    bit have_last = 0;
    int last_read_cyc = 0;

    int dir_avg[5]   = '{100, 104, 108, 112, 200};
    int dir_neg[4]   = '{-4, -4, -4, -3};
    int alarm_t[7]   = '{400, 400, 400, 400, 380, 388, 384};
    int alarm_o[7]   = '{0, 0, 0, 1, 1, 1, 0};
    int flt_t[10]    = '{420, 420, 420, 420, 0, 420, 0, 0, 0, 0};
    int flt_c[10]    = '{0, 0, 0, 0, 1, 0, 2, 4, 1, 6};
    int flt_l[10]    = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1};

    task automatic checkOutput(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int floorDiv(input int a, input int b);
        if (a >= 0) return a / b;
        return -((-a + b - 1) / b);
    endfunction

    task automatic modelReset();
        window.delete();
        m_avg = 0; m_valid = 0; m_over = 0; m_latched = 0;
        m_code = 0; m_timeout = 0; m_fcnt = 0;
    endtask

    task automatic modelSample(input int temp, input int fault);
        int s;
        if (fault == 0) begin
            m_fcnt = 0;
            window.push_back(temp);
            if (window.size() > WIN) void'(window.pop_front());
            s = 0;
            foreach (window[i]) s += window[i];
            m_avg   = floorDiv(s, WIN);
            m_valid = (window.size() == WIN) ? 1 : 0;
            if (m_valid == 1 && m_avg >= HI) m_over = 1;
            else if (m_valid == 0 || m_avg < HI - HYS) m_over = 0;
        end else begin
            if (m_fcnt < 15) m_fcnt++;
            if (m_latched == 0 && m_fcnt >= FLIM) begin
                m_latched = 1;
                m_code    = fault;
                window.delete();
                m_avg = 0; m_valid = 0; m_over = 0;
            end
        end
    endtask

    task automatic checkState(input string tag, input int exp_strobes, input int strobes);
        checkOutput({tag, "_avg"},     int'($signed(TEMP_AVG)), m_avg);
        checkOutput({tag, "_valid"},   int'(AVG_VALID),         m_valid);
        checkOutput({tag, "_over"},    int'(OVER_TEMP),         m_over);
        checkOutput({tag, "_latched"}, int'(FAULT_LATCHED),     m_latched);
        checkOutput({tag, "_code"},    int'(FAULT_CODE),        m_code);
        checkOutput({tag, "_timeout"}, int'(TIMEOUT_ERR),       m_timeout);
        checkOutput({tag, "_strobes"}, strobes,                 exp_strobes);
    endtask

    function automatic int packedOutputs();
        return int'({READ, AVG_VALID, SAMPLE_STROBE, OVER_TEMP, FAULT_LATCHED,
                     FAULT_CODE, TIMEOUT_ERR, TEMP_AVG});
    endfunction

    task automatic waitRead(output bit got);
        int n;
        got = 0;
        n = 0;
        while (!got && n < PERIOD + 64) begin
            @(negedge SYSCLK);
            n++;
            if (READ) got = 1;
        end
        if (!got) begin
            checkOutput("read_seen", 0, 1);
        end else begin
            if (have_last) checkOutput("read_spacing", cyc - last_read_cyc, PERIOD);
            last_read_cyc = cyc;
            have_last = 1;
        end
    endtask

    // One full reader transaction: answer READ, hold BUSY for a random time
    // with junk on the data lines, then present the sample on the falling edge.
    task automatic applyStimulus(input string tag, input int temp, input int fault,
                                 input bit drop_en);
        bit got;
        int d;
        int s0;
        waitRead(got);
        if (!got) return;
        if (drop_en) ENABLE = 1'b0;
        @(negedge SYSCLK);
        checkOutput("read_width", int'(READ), 0);
        d = $urandom_range(0, 5);
        repeat (d) @(negedge SYSCLK);
        BUSY_FLAG      = 1'b1;
        TEMPERATURE_TC = 14'($urandom);
        STATUS_FAULT   = 3'($urandom);
        d = $urandom_range(2, 300);
        repeat (d) @(negedge SYSCLK);
        TEMPERATURE_TC = temp[13:0];
        STATUS_FAULT   = fault[2:0];
        BUSY_FLAG      = 1'b0;
        s0 = strobe_cnt;
        repeat (4) @(negedge SYSCLK);
        modelSample(temp, fault);
        checkState(tag, (fault == 0) ? 1 : 0, strobe_cnt - s0);
    endtask

    task automatic pulseClear();
        @(negedge SYSCLK);
        FAULT_CLEAR = 1'b1;
        @(negedge SYSCLK);
        FAULT_CLEAR = 1'b0;
        @(negedge SYSCLK);
        m_latched = 0; m_code = 0; m_timeout = 0;
    endtask

    initial begin
        repeat (120000) @(posedge SYSCLK);
        $display("[TB] FAIL watchdog: got %0d cycles, expected completion", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit got;
        int reads, s0, en_cyc, temp, fault;

        RESET = 1'b1; ENABLE = 1'b0; BUSY_FLAG = 1'b0;
        STATUS_FAULT = '0; TEMPERATURE_TC = '0; FAULT_CLEAR = 1'b0;
        modelReset();
        repeat (3) @(negedge SYSCLK);
        checkOutput("reset_outputs", packedOutputs(), 0);
        ENABLE = 1'b1;
        RESET  = 1'b0;

        $display("[TB] averaging");
        for (int i = 0; i < 5; i++) begin
            applyStimulus("avg", dir_avg[i], 0, 0);
            if (i == 3) begin
                checkOutput("avg_106", int'($signed(TEMP_AVG)), 106);
                checkOutput("avg_valid_4th", int'(AVG_VALID), 1);
            end
        end
        checkOutput("avg_131", int'($signed(TEMP_AVG)), 131);

        $display("[TB] negative floor");
        for (int i = 0; i < 4; i++) applyStimulus("neg", dir_neg[i], 0, 0);
        checkOutput("avg_neg_floor", int'($signed(TEMP_AVG)), -4);

        $display("[TB] alarm hysteresis");
        for (int i = 0; i < 7; i++) begin
            applyStimulus("alarm", alarm_t[i], 0, 0);
            checkOutput("alarm_seq", int'(OVER_TEMP), alarm_o[i]);
        end

        $display("[TB] fault screening");
        for (int i = 0; i < 10; i++) begin
            applyStimulus("flt", flt_t[i], flt_c[i], 0);
            checkOutput("flt_latch_seq", int'(FAULT_LATCHED), flt_l[i]);
        end
        checkOutput("flt_code_kept", int'(FAULT_CODE), 1);
        pulseClear();
        checkOutput("clr_latched", int'(FAULT_LATCHED), 0);
        checkOutput("clr_code", int'(FAULT_CODE), 0);

        $display("[TB] random samples");
        for (int i = 0; i < 10; i++) begin
            temp  = int'($urandom_range(0, 900)) - 300;
            fault = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 7)) : 0;
            applyStimulus("rnd", temp, fault, 0);
        end
        if (m_latched != 0) pulseClear();

        $display("[TB] enable gating");
        applyStimulus("en_drop", 250, 0, 1);
        reads = 0;
        repeat (2 * PERIOD) begin
            @(negedge SYSCLK);
            if (READ) reads++;
        end
        checkOutput("no_read_disabled", reads, 0);
        ENABLE = 1'b1;
        en_cyc = cyc;
        have_last = 0;
        applyStimulus("en_resume", 260, 0, 0);
        checkOutput("resume_latency", last_read_cyc - en_cyc, 1);

        $display("[TB] start timeout");
        waitRead(got);
        repeat (10) @(negedge SYSCLK);
        checkOutput("timeout_early", int'(TIMEOUT_ERR), 0);
        repeat (15) @(negedge SYSCLK);
        m_timeout = 1;
        checkOutput("timeout_nobusy", int'(TIMEOUT_ERR), 1);
        applyStimulus("after_nobusy", 270, 0, 0);
        pulseClear();
        checkOutput("clr_timeout", int'(TIMEOUT_ERR), 0);

        $display("[TB] stuck busy");
        waitRead(got);
        @(negedge SYSCLK);
        BUSY_FLAG = 1'b1;
        reads = 0;
        s0 = strobe_cnt;
        repeat (BTO + 200) begin
            @(negedge SYSCLK);
            if (READ) reads++;
        end
        m_timeout = 1;
        checkOutput("timeout_stuck", int'(TIMEOUT_ERR), 1);
        checkOutput("stuck_no_read", reads, 0);
        checkOutput("stuck_no_strobe", strobe_cnt - s0, 0);
        BUSY_FLAG = 1'b0;
        have_last = 0;
        applyStimulus("after_stuck", 300, 0, 0);

        $display("[TB] reset during transaction");
        waitRead(got);
        @(negedge SYSCLK);
        BUSY_FLAG = 1'b1;
        repeat (20) @(negedge SYSCLK);
        #2 RESET = 1'b1;
        #1 checkOutput("async_reset_outputs", packedOutputs(), 0);
        @(negedge SYSCLK);
        BUSY_FLAG = 1'b0;
        @(negedge SYSCLK);
        RESET = 1'b0;
        modelReset();
        have_last = 0;
        applyStimulus("post_reset", 123, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
